// File: rtl/demux1to4_buf.sv
// 1-to-4 demultiplexer with a small FIFO per output channel.
// Optional per-channel accepted-word counters appear on Count when DEMUX1TO4_CNT_EN is defined.
module demux1to4_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic [1:0]       Sel,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Dout0,
  output logic [WIDTH-1:0] Dout1,
  output logic [WIDTH-1:0] Dout2,
  output logic [WIDTH-1:0] Dout3,
  output logic             OutValid0,
  output logic             OutValid1,
  output logic             OutValid2,
  output logic             OutValid3,
  input  logic             OutReady0,
  input  logic             OutReady1,
  input  logic             OutReady2,
  input  logic             OutReady3
`ifdef DEMUX1TO4_CNT_EN
  ,
  output logic [31:0]      Count
`endif
);

  // DEPTH is 2 or 4, so the pointers wrap naturally at their own width.
  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic [WIDTH-1:0] mem_q    [4][DEPTH];
  logic [WIDTH-1:0] mem_d    [4][DEPTH];
  logic [PW-1:0]    wr_ptr_q [4];
  logic [PW-1:0]    wr_ptr_d [4];
  logic [PW-1:0]    rd_ptr_q [4];
  logic [PW-1:0]    rd_ptr_d [4];
  logic [2:0]       occ_q    [4];
  logic [2:0]       occ_d    [4];
  logic [3:0]       out_ready;
  logic [3:0]       push;
  logic [3:0]       pop;

  assign out_ready = {OutReady3, OutReady2, OutReady1, OutReady0};

  // Ready looks only at registered occupancy: a full channel stays not-ready while draining.
  assign InReady = (occ_q[Sel] < 3'(DEPTH));

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < 4; k++) begin
      push[k] = InValid && InReady && (Sel == 2'(k));
      pop[k]  = out_ready[k] && (occ_q[k] != 3'd0);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    for (int k = 0; k < 4; k++) begin
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k]] = Din;
        wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
      end
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
      end
      occ_d[k] = occ_q[k] + {2'b00, push[k]} - {2'b00, pop[k]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        occ_q[k]    <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign Dout0     = mem_q[0][rd_ptr_q[0]];
  assign Dout1     = mem_q[1][rd_ptr_q[1]];
  assign Dout2     = mem_q[2][rd_ptr_q[2]];
  assign Dout3     = mem_q[3][rd_ptr_q[3]];
  assign OutValid0 = (occ_q[0] != 3'd0);
  assign OutValid1 = (occ_q[1] != 3'd0);
  assign OutValid2 = (occ_q[2] != 3'd0);
  assign OutValid3 = (occ_q[3] != 3'd0);

`ifdef DEMUX1TO4_CNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (push[k]) begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// Bench for demux1to4_buf: per-channel queue model plus directed scenarios and random traffic.
// Count checks are compiled in when DEMUX1TO4_CNT_EN is defined.
module tb_demux1to4_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] Din;
  logic [1:0]       Sel;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] dout0, dout1, dout2, dout3;
  logic             ov0, ov1, ov2, ov3;
  logic [3:0]       ordy;
`ifdef DEMUX1TO4_CNT_EN
  logic [31:0]      Count;
`endif

  demux1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(clk), .Reset(Reset), .Din(Din), .Sel(Sel), .InValid(InValid), .InReady(InReady),
    .Dout0(dout0), .Dout1(dout1), .Dout2(dout2), .Dout3(dout3),
    .OutValid0(ov0), .OutValid1(ov1), .OutValid2(ov2), .OutValid3(ov3),
    .OutReady0(ordy[0]), .OutReady1(ordy[1]), .OutReady2(ordy[2]), .OutReady3(ordy[3])
`ifdef DEMUX1TO4_CNT_EN
    , .Count(Count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int pops0  = 0;
  logic [WIDTH-1:0] q [4][$];
  int cnt_m [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] dout_of(input int k);
    case (k)
      0: return dout0;
      1: return dout1;
      2: return dout2;
      default: return dout3;
    endcase
  endfunction

  function automatic logic ov_of(input int k);
    case (k)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  // Scoreboard: compare against the queue model, then apply this cycle's transfers to it.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("outvalid%0d", k), 64'(ov_of(k)), 64'(q[k].size() > 0));
        if (q[k].size() > 0)
          chk($sformatf("dout%0d", k), 64'(dout_of(k)), 64'(q[k][0]));
      end
      chk("inready", 64'(InReady), 64'(q[Sel].size() < DEPTH));
`ifdef DEMUX1TO4_CNT_EN
      chk("count", 64'(Count), 64'({cnt_m[3][7:0], cnt_m[2][7:0], cnt_m[1][7:0], cnt_m[0][7:0]}));
`endif
      if (Reset) begin
        for (int k = 0; k < 4; k++) begin
          q[k].delete();
          cnt_m[k] = 0;
        end
      end else begin
        bit acc;
        acc = InValid && (q[Sel].size() < DEPTH);
        for (int k = 0; k < 4; k++) begin
          if (ordy[k] && q[k].size() > 0) begin
            void'(q[k].pop_front());
            if (k == 0) pops0++;
          end
        end
        if (acc) begin
          q[Sel].push_back(Din);
          cnt_m[Sel] = (cnt_m[Sel] + 1) % 256;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    InValid = 1'b0;
    ordy    = 4'h0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic push(input logic [1:0] s, input logic [WIDTH-1:0] d);
    InValid = 1'b1;
    Sel     = s;
    Din     = d;
    tick();
    InValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Din = '0; Sel = '0; InValid = 1'b0; ordy = 4'h0;
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    do_reset();
    mon_en = 1'b1;
    chk("reset_outvalid", 64'({ov3, ov2, ov1, ov0}), 64'h0);
    chk("reset_inready", 64'(InReady), 64'h1);

    // Route
    for (int i = 0; i < 4; i++) push(2'(i), WIDTH'(i));
    chk("route_outvalid", 64'({ov3, ov2, ov1, ov0}), 64'hF);
    for (int i = 0; i < 4; i++) chk($sformatf("route_dout%0d", i), 64'(dout_of(i)), 64'(i));
`ifdef DEMUX1TO4_CNT_EN
    chk("route_count", 64'(Count), 64'h01010101);
`endif

    // Full channel
    do_reset();
    push(2'd1, 'hA);
    push(2'd1, 'hB);
    InValid = 1'b1; Sel = 2'd1; Din = 'hC;
    #1;
    chk("full_inready", 64'(InReady), 64'h0);
    chk("full_head", 64'(dout1), 64'hA);
    ordy[1] = 1'b1;
    #1;
    chk("full_inready_popping", 64'(InReady), 64'h0);
    InValid = 1'b0;
    tick();
    ordy[1] = 1'b0;
    Sel = 2'd1;
    #1;
    chk("full_after_pop_dout", 64'(dout1), 64'hB);
    chk("full_after_pop_inready", 64'(InReady), 64'h1);

    // Concurrent push/pop
    do_reset();
    push(2'd2, 'h5);
    ordy[2] = 1'b1;
    push(2'd2, 'h6);
    ordy[2] = 1'b0;
    chk("conc_dout2", 64'(dout2), 64'h6);
    chk("conc_valid2", 64'(ov2), 64'h1);
    ordy[2] = 1'b1;
    tick();
    ordy[2] = 1'b0;
    chk("conc_occ1_drained", 64'(ov2), 64'h0);

    // Reset mid-operation, with a transfer presented during the reset cycle
    do_reset();
    for (int i = 0; i < 8; i++) push(2'(i % 4), WIDTH'(32'h100 + i));
    InValid = 1'b1; Sel = 2'd0; Din = 'hDEAD; ordy = 4'hF;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle();
    Sel = 2'd3;
    #1;
    chk("midrst_outvalid", 64'({ov3, ov2, ov1, ov0}), 64'h0);
    chk("midrst_inready", 64'(InReady), 64'h1);
    push(2'd3, 'h77);
    chk("midrst_dout3", 64'(dout3), 64'h77);
    chk("midrst_only3", 64'({ov3, ov2, ov1, ov0}), 64'h8);
    ordy[3] = 1'b1;
    tick();
    ordy[3] = 1'b0;
    chk("midrst_alone", 64'(ov3), 64'h0);

    // Wrap through channel 0
    do_reset();
    pops0 = 0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 10; i++) push(2'd0, WIDTH'(i));
    tick();
    tick();
    ordy[0] = 1'b0;
    chk("wrap_pops", 64'(pops0), 64'd10);
    chk("wrap_empty", 64'(ov0), 64'h0);
`ifdef DEMUX1TO4_CNT_EN
    chk("wrap_count0", 64'(Count[7:0]), 64'd10);

    // Counter wrap
    do_reset();
    push(2'd0, 'h1);
    ordy[1] = 1'b1;
    for (int i = 0; i < 256; i++) push(2'd1, WIDTH'(i));
    ordy[1] = 1'b0;
    chk("cntwrap_ch1", 64'(Count[15:8]), 64'h0);
    chk("cntwrap_others", 64'({Count[31:16], Count[7:0]}), 64'h000001);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      Reset   = ($urandom_range(0, 249) == 0);
      InValid = $urandom_range(0, 3) != 0;
      Sel     = 2'($urandom_range(0, 3));
      Din     = $urandom;
      ordy    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    Reset = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
